// File: rtl/rx_word_aligner.sv
// Serial-to-parallel deserializer with K28.5 comma word alignment.
// A HUNT/VERIFY/LOCKED machine locks the symbol boundary and emits aligned symbols.
//
// state  | meaning
// HUNT   | searching every bit position for a comma, nothing emitted
// VERIFY | boundary chosen, counting aligned commas toward lock
// LOCKED | boundary trusted, misaligned commas counted toward loss of lock
module rx_word_aligner #(
    parameter int              WIDTH      = 10,
    parameter logic [WIDTH-1:0] COMMA_P   = 10'b0011111010,
    parameter logic [WIDTH-1:0] COMMA_N   = 10'b1100000101,
    parameter int              LOCK_CNT   = 3,
    parameter int              UNLOCK_CNT = 4
) (
    input  logic             PI_Clk,
    input  logic             rst,
    input  logic             Din,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             is_comma,
    output logic             locked,
    output logic             realign
);

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(WIDTH - 1);
    localparam logic [3:0]      LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0]      UNLOCK_TH = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   sr;
    logic [WIDTH-1:0]     win;
    logic                 match;
    logic                 boundary;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [3:0]           ok_cnt;
    logic [3:0]           ok_nxt;
    logic [3:0]           ok_inc;
    logic [3:0]           err_cnt;
    logic [3:0]           err_nxt;
    logic [3:0]           err_inc;
    logic                 emit;
    logic                 realign_nxt;

    assign win      = sr[2*WIDTH-1:WIDTH];
    assign match    = (win == COMMA_P) || (win == COMMA_N);
    assign boundary = (cnt == CNT_MAX);
    assign ok_inc   = (ok_cnt == 4'hF) ? ok_cnt : ok_cnt + 4'd1;
    assign err_inc  = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = boundary ? '0 : cnt + CW'(1);
        ok_nxt      = ok_cnt;
        err_nxt     = err_cnt;
        emit        = 1'b0;
        realign_nxt = 1'b0;
        case (state)
            HUNT: begin
                // The comma itself defines the boundary, so the bit counter restarts here.
                if (match) begin
                    cnt_nxt = '0;
                    emit    = 1'b1;
                    ok_nxt  = 4'd1;
                    if (LOCK_CNT == 1) begin
                        state_nxt = LOCKED;
                        err_nxt   = '0;
                    end else begin
                        state_nxt = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (match) begin
                        ok_nxt = ok_inc;
                        if (ok_inc >= LOCK_TH) begin
                            state_nxt = LOCKED;
                            err_nxt   = '0;
                        end
                    end
                end else if (match) begin
                    state_nxt   = HUNT;
                    realign_nxt = 1'b1;
                    ok_nxt      = '0;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (match) begin
                        err_nxt = '0;
                    end
                end else if (match) begin
                    // Tolerate a few misaligned commas before giving up the boundary.
                    err_nxt = err_inc;
                    if (err_inc >= UNLOCK_TH) begin
                        state_nxt   = HUNT;
                        realign_nxt = 1'b1;
                        ok_nxt      = '0;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge PI_Clk) begin
        if (rst) begin
            state      <= HUNT;
            sr         <= '0;
            cnt        <= '0;
            ok_cnt     <= '0;
            err_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            is_comma   <= 1'b0;
            locked     <= 1'b0;
            realign    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= {Din, sr[2*WIDTH-1:1]};
            cnt        <= cnt_nxt;
            ok_cnt     <= ok_nxt;
            err_cnt    <= err_nxt;
            data_valid <= emit;
            locked     <= (state_nxt == LOCKED);
            realign    <= realign_nxt;
            if (emit) begin
                data_out <= win;
                is_comma <= match;
            end
        end
    end

endmodule
